fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_pkg.sv | 19 +
 rtl/fnd_seg_decoder.sv | 16 +
 rtl/fnd_scan_controller.sv | 178 +++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/fnd_seg_decoder.sv
// Hex nibble plus decimal point to active-low 7-segment code.
// Purely combinational; the controller registers the result.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] lut_seg;

  assign lut_seg = SEG_LUT[hex];
  assign seg     = {lut_seg[7] & ~dp, lut_seg[6:0]};

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed FND scanner with anti-ghost blanking and frame-aligned updates.
// Optional blinking enabled by defining FND_BLINK_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYC     = 100_000,
  parameter int BLANK_CYC    = 1_000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lzb_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              fnd_data,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic                    frame_tick
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BL   = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BL);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_e          state_q, state_d;
  logic            run_q;
  logic [IW-1:0]   idx_q, idx_d, idx_nxt;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   pend_q, pend_d, shd_q, shd_d, upper;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d, sdp_q, sdp_d;
  logic [7:0]      data_q, data_d, dec_seg, show_seg;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic            tick_q;
  logic            adv, frame, lz, blink_hit;

  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    adv     = 1'b0;
    if (!run_q) begin
      // first edge after reset opens a fresh frame on digit 0
      state_d = ST_SHOW;
      idx_d   = '0;
      cnt_d   = '0;
      adv     = 1'b1;
    end else begin
      unique case (state_q)
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (BLANK_CYC == 0) begin
              idx_d = idx_nxt;
              adv   = 1'b1;
            end else begin
              state_d = ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            idx_d   = idx_nxt;
            adv     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame  = adv && (idx_d == '0);
  assign pend_d = load ? data_in : pend_q;
  assign pdp_d  = load ? dp_in : pdp_q;
  assign shd_d  = frame ? pend_d : shd_q;
  assign sdp_d  = frame ? pdp_d : sdp_q;

  assign upper = shd_d >> {idx_d, 2'b00};
  assign lz    = lzb_en && (idx_d != '0) && (upper == '0);

  fnd_seg_decoder u_dec (
    .hex (shd_d[{idx_d, 2'b00} +: 4]),
    .dp  (sdp_d[idx_d]),
    .seg (dec_seg)
  );

`ifdef FND_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame && run_q) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_hit = phase_d & blink_mask[idx_d];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
  assign blink_hit    = 1'b0;
`endif

  always_comb begin
    if (blink_hit)
      show_seg = SEG_BLANK;
    else if (lz)
      show_seg = {dec_seg[7], 7'h7F};
    else
      show_seg = dec_seg;
  end

  assign data_d = (state_d == ST_SHOW) ? show_seg : SEG_BLANK;
  assign com_d  = (state_d == ST_SHOW) ?
                  ~(NUM_DIGITS'(1) << idx_d) : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      state_q <= ST_SHOW;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      shd_q   <= '0;
      sdp_q   <= '0;
      data_q  <= SEG_BLANK;
      com_q   <= '1;
      tick_q  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      shd_q   <= shd_d;
      sdp_q   <= sdp_d;
      data_q  <= data_d;
      com_q   <= com_d;
      tick_q  <= frame;
    end
  end

  assign fnd_data   = data_q;
  assign fnd_com    = com_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (4 digits, 4/1 scan timing).
// Blink expectations follow FND_BLINK_EN when defined.
module tb_fnd_scan_controller;

  localparam int N  = 4;
  localparam int SC = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam int FR = N * (SC + BC);

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lzb_en;
  logic [3:0]  blink_mask;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;
  logic        frame_tick;

  fnd_scan_controller #(
    .NUM_DIGITS   (N),
    .SHOW_CYC     (SC),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .lzb_en     (lzb_en),
    .blink_mask (blink_mask),
    .fnd_data   (fnd_data),
    .fnd_com    (fnd_com),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            lzb;
    logic [3:0][7:0] seg;
  } vec_t;

  int          n_chk;
  int          n_fail;
  int          t;
  int          fnum;
  int          last_tick;
  logic [15:0] m_pd, m_sd;
  logic [3:0]  m_pdp, m_sdp;
  logic [16:0] sbq[$];
  logic [7:0]  lut[16];
  logic [7:0]  obs[4];
  vec_t        vt[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  function automatic logic [7:0] mseg(input logic [15:0] d,
                                      input logic [3:0] p,
                                      input logic lz, input int g,
                                      input logic blk);
    logic [7:0]  s;
    logic [15:0] up;
    s  = lut[d[g*4+:4]];
    if (p[g]) s[7] = 1'b0;
    up = d >> (4 * g);
    if (lz && g > 0 && up == 16'h0) s[6:0] = 7'h7F;
    if (blk) s = 8'hFF;
    return s;
  endfunction

  task automatic step();
    int         pos, dig;
    logic       blank, ph;
    logic [3:0] com;
    logic [7:0] sg;
    logic [16:0] e;
    t++;
    pos = (t - 1) % FR;
    if (load) begin
      m_pd  = data_in;
      m_pdp = dp_in;
    end
    if (pos == 0) begin
      m_sd  = m_pd;
      m_sdp = m_pdp;
      fnum++;
    end
    dig   = pos / (SC + BC);
    blank = (pos % (SC + BC)) == SC;
    ph    = 1'b0;
`ifdef FND_BLINK_EN
    ph = (((fnum - 1) / BF) % 2) == 1;
`endif
    if (blank) begin
      com = 4'hF;
      sg  = 8'hFF;
    end else begin
      com = ~(4'b0001 << dig);
      sg  = mseg(m_sd, m_sdp, lzb_en, dig, ph && blink_mask[dig]);
    end
    sbq.push_back({pos == 0, com, sg});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("scan", {15'd0, frame_tick, fnd_com, fnd_data}, {15'd0, e});
    if (frame_tick) begin
      if (last_tick > 0) check("tick_period", t - last_tick, FR);
      last_tick = t;
    end
    if (!blank) obs[dig] = fnd_data;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_com", fnd_com, 4'hF);
    check("rst_data", fnd_data, 8'hFF);
    check("rst_tick", frame_tick, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_com", fnd_com, 4'hF);
    rst_n     = 1'b1;
    t         = 0;
    fnum      = 0;
    last_tick = 0;
    m_pd      = '0;
    m_sd      = '0;
    m_pdp     = '0;
    m_sdp     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vt[0] = '{16'h12AF, 4'b0100, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}};
    vt[1] = '{16'h0070, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
    vt[2] = '{16'h0070, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hF8, 8'hC0}};
    vt[3] = '{16'h0800, 4'b0000, 1'b1, {8'hFF, 8'h80, 8'hC0, 8'hC0}};
    vt[4] = '{16'h0000, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'hC0}};
    vt[5] = '{16'hFFFF, 4'b1111, 1'b1, {8'h0E, 8'h0E, 8'h0E, 8'h0E}};
    vt[6] = '{16'h3B5D, 4'b0001, 1'b0, {8'hB0, 8'h83, 8'h92, 8'h21}};
    vt[7] = '{16'h0009, 4'b0010, 1'b1, {8'hFF, 8'hFF, 8'h7F, 8'h90}};
    n_chk      = 0;
    n_fail     = 0;
    t          = 0;
    rst_n      = 1'b1;
    load       = 1'b0;
    data_in    = '0;
    dp_in      = '0;
    lzb_en     = 1'b0;
    blink_mask = '0;
    #16;
    do_reset();

    step();
    check("first_com", fnd_com, 4'b1110);
    check("first_tick", frame_tick, 1'b1);
    check("first_data", fnd_data, 8'hC0);
    run(4);
    check("first_blank", fnd_com, 4'b1111);
    step();
    check("second_com", fnd_com, 4'b1101);
    run(FR - 6);

    foreach (vt[v]) begin
      for (int i = 0; i < FR; i++) begin
        if (i == 7) begin
          load    = 1'b1;
          data_in = vt[v].data;
          dp_in   = vt[v].dp;
        end
        step();
      end
      lzb_en = vt[v].lzb;
      run(FR);
      for (int d = 0; d < N; d++)
        check("vec_digit", obs[d], vt[v].seg[d]);
    end

    lzb_en  = 1'b0;
    load    = 1'b1;
    data_in = 16'h4321;
    dp_in   = 4'b0000;
    step();
    check("coincident_d0", fnd_data, 8'hF9);
    check("coincident_tick", frame_tick, 1'b1);
    run(FR - 1);
    check("coincident_d3", obs[3], 8'h99);
    check("coincident_d2", obs[2], 8'hB0);

    blink_mask = 4'b0001;
    run(5 * FR);
    blink_mask = 4'b0000;

    run(12);
    check("pre_rst_com", fnd_com, 4'b1011);
    do_reset();
    run(FR);
    for (int d = 0; d < N; d++)
      check("post_rst_digit", obs[d], 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
